ifu_fetch1: RTL

PC-generation and instruction-fetch stage (IF1) of the in-order pipeline. It owns the architectural fetch PC, issues single-outstanding requests to instruction memory, absorbs redirects from the back end, and presents one fetched instruction at a time, with its commit-info bundle, to the IF1/IF2 pipeline register. When no valid instruction is held, it drives an all-zero bubble.

---
 rtl/ifu_fetch1.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch1.sv
// ifu_fetch1 -- PC generation and instruction fetch (IF1).
//
// Owns the architectural fetch PC, keeps at most one request in flight to
// instruction memory, absorbs back-end redirects and holds one fetched
// instruction at a time for the IF1/IF2 register. An empty slot is presented
// as an all-zero bubble.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   redirect_valid/_pc    back-end redirect; target low two bits ignored
//   fetch_stall           downstream stall, only meaningful while holding
//   imem_req_*            request channel (valid/addr out, ready in)
//   imem_resp_*           one-cycle response strobe and instruction word
//   fetch_o_*             held instruction, its PC and the commit-info bundle
//                         {valid, pc, pc+4, instr}
module ifu_fetch1 #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    input  logic         fetch_stall,
    output logic         imem_req_valid,
    output logic [63:0]  imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    output logic         fetch_o_valid,
    output logic [63:0]  fetch_o_pc,
    output logic [31:0]  fetch_o_instr,
    output logic [160:0] fetch_o_commit_info
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [63:0] out_npc_q, out_npc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [63:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~64'h3;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_npc_d   = out_npc_q;
        out_instr_d = out_instr_q;

        unique case (state_q)
            S_REQ: begin
                // A pending request may be retargeted; once accepted by
                // memory, a redirect must drain the response it will produce.
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_req_ready ? S_DRAIN : S_REQ;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_resp_valid ? S_REQ : S_DRAIN;
                end else if (imem_resp_valid) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    out_npc_d   = pc_q + 64'd4;
                    out_instr_d = imem_resp_data;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (!fetch_stall) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = S_REQ;
                end
            end
            default: begin // S_DRAIN
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
        endcase

        // Leaving HOLD (consumed or redirected) or any redirect empties the
        // output slot; zeroed fields keep the bubble identical to a flush.
        if (state_d != S_HOLD) begin
            out_valid_d = 1'b0;
            out_pc_d    = 64'd0;
            out_npc_d   = 64'd0;
            out_instr_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 64'd0;
            out_npc_q   <= 64'd0;
            out_instr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_npc_q   <= out_npc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign imem_req_valid      = (state_q == S_REQ);
    assign imem_req_addr       = pc_q;
    assign fetch_o_valid       = out_valid_q;
    assign fetch_o_pc          = out_pc_q;
    assign fetch_o_instr       = out_instr_q;
    assign fetch_o_commit_info = {out_valid_q, out_pc_q, out_npc_q, out_instr_q};

endmodule
